// File: rtl/qtcore_ctrl_pkg.sv
// Shared types and default sizing for the qtcore boot controller.
package qtcore_ctrl_pkg;

    localparam int unsigned DEF_CHAIN_LEN = 200;
    localparam int unsigned DEF_MAX_RUN   = 4096;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_WAIT,
        ST_LOAD_SHIFT,
        ST_RUN,
        ST_DUMP_SHIFT,
        ST_DUMP_HOLD,
        ST_DONE
    } state_e;

endpackage

// File: rtl/qtcore_boot_ctrl_if.sv
// Host-side byte interface of the qtcore boot controller: command, load stream, readback stream, status.
interface qtcore_boot_ctrl_if;

    logic       start;
    logic [7:0] ld_data;
    logic       ld_valid;
    logic       ld_ready;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_ready;
    logic       busy;
    logic       done;
    logic       timeout;

    modport master (
        output start, ld_data, ld_valid, rd_ready,
        input  ld_ready, rd_data, rd_valid, busy, done, timeout
    );

    modport slave (
        input  start, ld_data, ld_valid, rd_ready,
        output ld_ready, rd_data, rd_valid, busy, done, timeout
    );

endinterface

// File: rtl/qtcore_bit_shifter.sv
// 8-bit parallel-load / serial shift register with a bit counter; last flags the 8th shift.
module qtcore_bit_shifter (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_data,
    input  logic       shift,
    input  logic       ser_in,
    output logic       ser_out,
    output logic [7:0] par_next,
    output logic       last
);

    logic [7:0] sr_q, sr_d;
    logic [2:0] cnt_q, cnt_d;

    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (load) begin
            sr_d  = load_data;
            cnt_d = '0;
        end else if (shift) begin
            sr_d  = {sr_q[6:0], ser_in};
            cnt_d = cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

    assign ser_out  = sr_q[7];
    assign par_next = sr_d;
    assign last     = shift && (cnt_q == 3'd7);

endmodule

// File: rtl/qtcore_boot_ctrl.sv
// Scan-chain boot sequencer: loads an image into the core, runs it to halt or timeout,
// then reads the whole chain back while recirculating it.
module qtcore_boot_ctrl
    import qtcore_ctrl_pkg::*;
#(
    parameter int unsigned CHAIN_LEN = DEF_CHAIN_LEN,
    parameter int unsigned MAX_RUN   = DEF_MAX_RUN
) (
    input  logic                clk,
    input  logic                rst,
    qtcore_boot_ctrl_if.slave   host,
    output logic                scan_enable,
    output logic                scan_in,
    input  logic                scan_out,
    output logic                proc_en,
    input  logic                halt
);

    localparam int unsigned NBYTES = CHAIN_LEN / 8;
    localparam int unsigned BW     = $clog2(NBYTES + 1);
    localparam int unsigned RW     = $clog2(MAX_RUN + 1);

    state_e          state_q, state_d;
    logic [BW-1:0]   byte_cnt_q, byte_cnt_d;
    logic [RW-1:0]   run_cnt_q, run_cnt_d;
    logic            timeout_q, timeout_d;
    logic [7:0]      rd_data_q, rd_data_d;
    logic            ld_ready_q, ld_ready_d;
    logic            rd_valid_q, rd_valid_d;
    logic            scan_enable_q, scan_enable_d;
    logic            proc_en_q, proc_en_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic            sh_load, sh_shift, sh_ser_out, sh_last;
    logic [7:0]      sh_next;

    qtcore_bit_shifter u_shifter (
        .clk       (clk),
        .rst       (rst),
        .load      (sh_load),
        .load_data (host.ld_data),
        .shift     (sh_shift),
        .ser_in    (scan_out),
        .ser_out   (sh_ser_out),
        .par_next  (sh_next),
        .last      (sh_last)
    );

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        run_cnt_d  = run_cnt_q;
        timeout_d  = timeout_q;
        rd_data_d  = rd_data_q;
        sh_load    = 1'b0;
        sh_shift   = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (host.start) begin
                    state_d    = ST_LOAD_WAIT;
                    timeout_d  = 1'b0;
                    byte_cnt_d = '0;
                end
            end
            ST_LOAD_WAIT: begin
                if (host.ld_valid && ld_ready_q) begin
                    sh_load = 1'b1;
                    state_d = ST_LOAD_SHIFT;
                end
            end
            ST_LOAD_SHIFT: begin
                sh_shift = 1'b1;
                if (sh_last) begin
                    // byte counter is reused for the dump, so it restarts on entering RUN
                    if (byte_cnt_q == BW'(NBYTES - 1)) begin
                        byte_cnt_d = '0;
                        run_cnt_d  = '0;
                        state_d    = ST_RUN;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                        state_d    = ST_LOAD_WAIT;
                    end
                end
            end
            ST_RUN: begin
                run_cnt_d = run_cnt_q + 1'b1;
                if (halt) begin
                    state_d = ST_DUMP_SHIFT;
                end else if (run_cnt_d == RW'(MAX_RUN)) begin
                    timeout_d = 1'b1;
                    state_d   = ST_DUMP_SHIFT;
                end
            end
            ST_DUMP_SHIFT: begin
                sh_shift = 1'b1;
                if (sh_last) begin
                    rd_data_d = sh_next;
                    state_d   = ST_DUMP_HOLD;
                end
            end
            ST_DUMP_HOLD: begin
                if (host.rd_ready) begin
                    byte_cnt_d = byte_cnt_q + 1'b1;
                    state_d    = (byte_cnt_q == BW'(NBYTES - 1)) ? ST_DONE : ST_DUMP_SHIFT;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        ld_ready_d    = (state_d == ST_LOAD_WAIT);
        rd_valid_d    = (state_d == ST_DUMP_HOLD);
        scan_enable_d = (state_d == ST_LOAD_SHIFT) || (state_d == ST_DUMP_SHIFT);
        proc_en_d     = (state_d == ST_RUN);
        busy_d        = (state_d != ST_IDLE) && (state_d != ST_DONE);
        done_d        = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            byte_cnt_q    <= '0;
            run_cnt_q     <= '0;
            timeout_q     <= 1'b0;
            rd_data_q     <= '0;
            ld_ready_q    <= 1'b0;
            rd_valid_q    <= 1'b0;
            scan_enable_q <= 1'b0;
            proc_en_q     <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            byte_cnt_q    <= byte_cnt_d;
            run_cnt_q     <= run_cnt_d;
            timeout_q     <= timeout_d;
            rd_data_q     <= rd_data_d;
            ld_ready_q    <= ld_ready_d;
            rd_valid_q    <= rd_valid_d;
            scan_enable_q <= scan_enable_d;
            proc_en_q     <= proc_en_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    // Dump recirculation must be a direct tail-to-head path; a flop here would lengthen the loop by one bit.
    assign scan_in = (state_q == ST_LOAD_SHIFT) ? sh_ser_out :
                     (state_q == ST_DUMP_SHIFT) ? scan_out   : 1'b0;

    assign scan_enable   = scan_enable_q;
    assign proc_en       = proc_en_q;
    assign host.ld_ready = ld_ready_q;
    assign host.rd_valid = rd_valid_q;
    assign host.rd_data  = rd_data_q;
    assign host.busy     = busy_q;
    assign host.done     = done_q;
    assign host.timeout  = timeout_q;

endmodule

// File: tb/tb_qtcore_boot_ctrl.sv
// Directed bench for qtcore_boot_ctrl with a 16-bit behavioural scan chain and a halt model.
module tb_qtcore_boot_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic scan_enable, scan_in, scan_out, proc_en, halt;

    qtcore_boot_ctrl_if host_if ();

    qtcore_boot_ctrl #(.CHAIN_LEN(16), .MAX_RUN(10)) dut (
        .clk         (clk),
        .rst         (rst),
        .host        (host_if),
        .scan_enable (scan_enable),
        .scan_in     (scan_in),
        .scan_out    (scan_out),
        .proc_en     (proc_en),
        .halt        (halt)
    );

    always #5 clk = ~clk;

    logic [15:0] chain    = '0;
    logic [63:0] scan_log = '0;
    int se_total = 0, pe_total = 0, both_total = 0;
    int pe_base = 0, halt_at = 0;
    int n_checks = 0, n_fail = 0;

    assign scan_out = chain[15];
    assign halt = (halt_at != 0) && proc_en && ((pe_total - pe_base) >= (halt_at - 1));

    always @(posedge clk) begin
        if (scan_enable) begin
            chain    <= {chain[14:0], scan_in};
            scan_log <= {scan_log[62:0], scan_in};
            se_total <= se_total + 1;
        end
        if (proc_en) pe_total <= pe_total + 1;
        if (proc_en && scan_enable) both_total <= both_total + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, output bit ok);
        ok = 1'b0;
        host_if.ld_data  = b;
        host_if.ld_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (host_if.ld_ready) begin
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
        host_if.ld_valid = 1'b0;
    endtask

    task automatic wait_rd(output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (host_if.rd_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
            n++;
        end
    endtask

    task automatic run_seq(input logic [7:0] b0, input logic [7:0] b1, input int ld_gap,
                           input int rd_gap, input bit hold_ready,
                           output logic [7:0] r0, output logic [7:0] r1, output int n1,
                           output bit ok, output int stall_bad, output logic lr0,
                           output logic to_dump);
        bit k;
        int n, s;
        ok = 1'b1;
        stall_bad = 0;
        pe_base = pe_total;
        host_if.start = 1'b1;
        tick();
        host_if.start = 1'b0;
        lr0 = host_if.ld_ready;
        send_byte(b0, k);
        ok = ok & k;
        if (ld_gap > 0) begin
            repeat (8) tick();
            s = se_total;
            repeat (ld_gap) begin
                if (host_if.ld_ready !== 1'b1) stall_bad++;
                tick();
            end
            if (se_total != s) stall_bad++;
        end
        send_byte(b1, k);
        ok = ok & k;
        host_if.rd_ready = hold_ready;
        wait_rd(n, k);
        ok = ok & k;
        r0 = host_if.rd_data;
        to_dump = host_if.timeout;
        if (rd_gap > 0) begin
            s = se_total;
            repeat (rd_gap) begin
                tick();
                if (host_if.rd_data !== r0 || host_if.rd_valid !== 1'b1) stall_bad++;
            end
            if (se_total != s) stall_bad++;
        end
        host_if.rd_ready = 1'b1;
        tick();
        host_if.rd_ready = hold_ready;
        wait_rd(n1, k);
        ok = ok & k;
        r1 = host_if.rd_data;
        host_if.rd_ready = 1'b1;
        tick();
        host_if.rd_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [17:0] outs;
        rst = 1'b1;
        repeat (3) tick();
        outs = {host_if.ld_ready, host_if.rd_valid, host_if.rd_data, scan_enable, scan_in,
                proc_en, host_if.busy, host_if.done, host_if.timeout, 2'b00};
        n_checks++; if (outs !== 18'h0) begin n_fail++; $display("FAIL reset_outputs: got %h expected 0", outs); end
        rst = 1'b0;
        tick();
        tick();
        n_checks++; if ({host_if.busy, host_if.ld_ready, host_if.done} !== 3'b000) begin n_fail++; $display("FAIL idle_flags: got %b expected 000", {host_if.busy, host_if.ld_ready, host_if.done}); end
    endtask

    task automatic test_basic();
        logic [7:0] r0, r1;
        int n1, sb, se0;
        bit ok;
        logic lr0, td;
        halt_at = 5;
        se0 = se_total;
        run_seq(8'hA5, 8'h3C, 0, 0, 1'b1, r0, r1, n1, ok, sb, lr0, td);
        n_checks++; if (lr0 !== 1'b1) begin n_fail++; $display("FAIL basic_ld_ready_after_start: got %b expected 1", lr0); end
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL basic_handshake_timeout: got %b expected 1", ok); end
        n_checks++; if (r0 !== 8'hA5) begin n_fail++; $display("FAIL basic_rd0: got %h expected a5", r0); end
        n_checks++; if (r1 !== 8'h3C) begin n_fail++; $display("FAIL basic_rd1: got %h expected 3c", r1); end
        n_checks++; if (n1 !== 8) begin n_fail++; $display("FAIL basic_rd1_latency: got %0d expected 8", n1); end
        n_checks++; if (pe_total - pe_base !== 5) begin n_fail++; $display("FAIL basic_proc_en_cycles: got %0d expected 5", pe_total - pe_base); end
        n_checks++; if (se_total - se0 !== 32) begin n_fail++; $display("FAIL basic_shift_count: got %0d expected 32", se_total - se0); end
        n_checks++; if (scan_log[31:0] !== 32'hA53CA53C) begin n_fail++; $display("FAIL basic_scan_in_seq: got %h expected a53ca53c", scan_log[31:0]); end
        n_checks++; if (chain !== 16'hA53C) begin n_fail++; $display("FAIL basic_chain: got %h expected a53c", chain); end
        n_checks++; if ({host_if.done, host_if.busy, host_if.timeout, host_if.rd_valid} !== 4'b1000) begin n_fail++; $display("FAIL basic_done_flags: got %b expected 1000", {host_if.done, host_if.busy, host_if.timeout, host_if.rd_valid}); end
    endtask

    task automatic test_timeout();
        logic [7:0] r0, r1;
        int n1, sb;
        bit ok;
        logic lr0, td;
        halt_at = 0;
        run_seq(8'h96, 8'h0F, 0, 0, 1'b1, r0, r1, n1, ok, sb, lr0, td);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL to_handshake_timeout: got %b expected 1", ok); end
        n_checks++; if (pe_total - pe_base !== 10) begin n_fail++; $display("FAIL to_proc_en_cycles: got %0d expected 10", pe_total - pe_base); end
        n_checks++; if (td !== 1'b1) begin n_fail++; $display("FAIL to_flag_in_dump: got %b expected 1", td); end
        n_checks++; if (host_if.timeout !== 1'b1 || host_if.done !== 1'b1) begin n_fail++; $display("FAIL to_flag_in_done: got %b%b expected 11", host_if.timeout, host_if.done); end
        n_checks++; if ({r0, r1} !== 16'h960F) begin n_fail++; $display("FAIL to_readback: got %h expected 960f", {r0, r1}); end
        n_checks++; if (chain !== 16'h960F) begin n_fail++; $display("FAIL to_chain_unchanged: got %h expected 960f", chain); end
    endtask

    task automatic test_halt_at_limit();
        logic [7:0] r0, r1;
        int n1, sb;
        bit ok;
        logic lr0, td;
        halt_at = 10;
        run_seq(8'h12, 8'h34, 0, 0, 1'b0, r0, r1, n1, ok, sb, lr0, td);
        n_checks++; if (pe_total - pe_base !== 10) begin n_fail++; $display("FAIL coincide_proc_en_cycles: got %0d expected 10", pe_total - pe_base); end
        n_checks++; if (td !== 1'b0 || host_if.timeout !== 1'b0) begin n_fail++; $display("FAIL coincide_timeout: got %b%b expected 00", td, host_if.timeout); end
        n_checks++; if ({r0, r1} !== 16'h1234) begin n_fail++; $display("FAIL coincide_readback: got %h expected 1234", {r0, r1}); end
    endtask

    task automatic test_stalls();
        logic [7:0] r0, r1;
        int n1, sb, se0;
        bit ok;
        logic lr0, td;
        halt_at = 2;
        se0 = se_total;
        run_seq(8'hC9, 8'h71, 20, 7, 1'b0, r0, r1, n1, ok, sb, lr0, td);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL stall_handshake_timeout: got %b expected 1", ok); end
        n_checks++; if (sb !== 0) begin n_fail++; $display("FAIL stall_activity: got %0d anomalies expected 0", sb); end
        n_checks++; if ({r0, r1} !== 16'hC971) begin n_fail++; $display("FAIL stall_readback: got %h expected c971", {r0, r1}); end
        n_checks++; if (se_total - se0 !== 32 || scan_log[31:0] !== 32'hC971C971) begin n_fail++; $display("FAIL stall_scan: got %0d/%h expected 32/c971c971", se_total - se0, scan_log[31:0]); end
    endtask

    task automatic test_reset_mid_load();
        logic [7:0] r0, r1;
        logic [17:0] outs;
        int n1, sb;
        bit ok, k;
        logic lr0, td;
        host_if.start = 1'b1;
        tick();
        host_if.start = 1'b0;
        send_byte(8'hFF, k);
        repeat (8) tick();
        send_byte(8'h00, k);
        repeat (3) tick();
        n_checks++; if (scan_enable !== 1'b1 || host_if.busy !== 1'b1) begin n_fail++; $display("FAIL rst_pre_shift: got %b%b expected 11", scan_enable, host_if.busy); end
        #3 rst = 1'b1;
        #1;
        outs = {host_if.ld_ready, host_if.rd_valid, host_if.rd_data, scan_enable, scan_in,
                proc_en, host_if.busy, host_if.done, host_if.timeout, 2'b00};
        n_checks++; if (outs !== 18'h0) begin n_fail++; $display("FAIL rst_async_outputs: got %h expected 0", outs); end
        tick();
        rst = 1'b0;
        tick();
        halt_at = 3;
        run_seq(8'h5A, 8'hC3, 0, 0, 1'b1, r0, r1, n1, ok, sb, lr0, td);
        n_checks++; if ({r0, r1} !== 16'h5AC3 || chain !== 16'h5AC3) begin n_fail++; $display("FAIL rst_reload: got %h/%h expected 5ac3/5ac3", {r0, r1}, chain); end
        n_checks++; if (pe_total - pe_base !== 3 || td !== 1'b0) begin n_fail++; $display("FAIL rst_reload_run: got %0d/%b expected 3/0", pe_total - pe_base, td); end
    endtask

    task automatic test_start_ignored();
        logic [7:0] r0, r1;
        int n;
        bit k, ok;
        halt_at = 6;
        pe_base = pe_total;
        ok = 1'b1;
        host_if.start = 1'b1;
        tick();
        host_if.start = 1'b0;
        send_byte(8'hE7, k);
        ok = ok & k;
        send_byte(8'h18, k);
        ok = ok & k;
        k = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (proc_en) begin k = 1'b1; break; end
            tick();
        end
        ok = ok & k;
        host_if.start = 1'b1;
        tick();
        host_if.start = 1'b0;
        n_checks++; if ({proc_en, host_if.ld_ready, host_if.busy} !== 3'b101) begin n_fail++; $display("FAIL ign_start_run: got %b expected 101", {proc_en, host_if.ld_ready, host_if.busy}); end
        host_if.rd_ready = 1'b0;
        wait_rd(n, k);
        ok = ok & k;
        r0 = host_if.rd_data;
        host_if.start = 1'b1;
        tick();
        host_if.start = 1'b0;
        n_checks++; if (host_if.rd_valid !== 1'b1 || host_if.rd_data !== r0 || host_if.ld_ready !== 1'b0) begin n_fail++; $display("FAIL ign_start_hold: got %b/%h/%b expected 1/%h/0", host_if.rd_valid, host_if.rd_data, host_if.ld_ready, r0); end
        host_if.rd_ready = 1'b1;
        tick();
        host_if.rd_ready = 1'b0;
        host_if.start = 1'b1;
        tick();
        host_if.start = 1'b0;
        n_checks++; if (scan_enable !== 1'b1 || host_if.ld_ready !== 1'b0) begin n_fail++; $display("FAIL ign_start_dump: got %b%b expected 10", scan_enable, host_if.ld_ready); end
        wait_rd(n, k);
        ok = ok & k;
        r1 = host_if.rd_data;
        host_if.rd_ready = 1'b1;
        tick();
        host_if.rd_ready = 1'b0;
        n_checks++; if (ok !== 1'b1 || host_if.done !== 1'b1) begin n_fail++; $display("FAIL ign_completion: got %b%b expected 11", ok, host_if.done); end
        n_checks++; if ({r0, r1} !== 16'hE718 || pe_total - pe_base !== 6) begin n_fail++; $display("FAIL ign_result: got %h/%0d expected e718/6", {r0, r1}, pe_total - pe_base); end
    endtask

    initial begin
        rst = 1'b1;
        host_if.start    = 1'b0;
        host_if.ld_data  = '0;
        host_if.ld_valid = 1'b0;
        host_if.rd_ready = 1'b0;
        test_reset();
        test_basic();
        test_timeout();
        test_halt_at_limit();
        test_stalls();
        test_reset_mid_load();
        test_start_ignored();
        n_checks++; if (both_total !== 0) begin n_fail++; $display("FAIL scan_proc_overlap: got %0d cycles expected 0", both_total); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
